// File: rtl/dcache_ram_arbiter.sv
// Data-cache SRAM arbiter: picks one of NR_PORTS requesters per cycle,
// forwards its command to the way-banked SRAM and evaluates per-way tag
// hits for the granted read one cycle later.
//
// Request/grant semantics: a port requests while any bit of its req_i way
// mask is set and holds its command stable; gnt_o is combinational in that
// same cycle, and a request counts as consumed only in a cycle where its
// gnt_o bit is 1. There is no backpressure on the read return: rvalid_o is
// a single-cycle pulse, one cycle after the read grant.
module dcache_ram_arbiter #(
    parameter int NR_PORTS = 4,
    parameter int NR_WAYS  = 8,
    parameter int INDEX_W  = 12,
    parameter int TAG_W    = 44,
    parameter int LINE_W   = 128,
    parameter int RR_MODE  = 1
) (
    input  logic                               clk_i,
    input  logic                               clr_i,
    input  logic [NR_PORTS-1:0][NR_WAYS-1:0]   req_i,
    input  logic [NR_PORTS-1:0][INDEX_W-1:0]   addr_i,
    input  logic [NR_PORTS-1:0]                we_i,
    input  logic [NR_PORTS-1:0][LINE_W-1:0]    wdata_i,
    input  logic [NR_PORTS-1:0][LINE_W/8-1:0]  be_i,
    input  logic [NR_PORTS-1:0][TAG_W-1:0]     tag_i,
    input  logic [NR_PORTS-1:0]                lock_i,
    output logic [NR_PORTS-1:0]                gnt_o,
    output logic [NR_PORTS-1:0]                rvalid_o,
    output logic [NR_WAYS-1:0]                 hit_way_o,
    output logic                               hit_o,
    output logic                               multi_hit_o,
    output logic [NR_WAYS-1:0]                 ram_req_o,
    output logic [INDEX_W-1:0]                 ram_addr_o,
    output logic                               ram_we_o,
    output logic [LINE_W-1:0]                  ram_wdata_o,
    output logic [LINE_W/8-1:0]                ram_be_o,
    input  logic [NR_WAYS-1:0][TAG_W-1:0]      ram_tag_i,
    input  logic [NR_WAYS-1:0]                 ram_valid_i
);

    localparam int PW = $clog2(NR_PORTS);

    logic [PW-1:0]       rr_q;
    logic                lock_valid_q;
    logic [PW-1:0]       lock_id_q;
    logic [PW-1:0]       id_q;
    logic                rd_q;

    logic [NR_PORTS-1:0] eligible;
    logic [PW-1:0]       rr_start;
    logic                win_valid;
    logic [PW-1:0]       win_id;

    // Fixed priority simply starts the search at port 0 every cycle.
    assign rr_start = (RR_MODE != 0) ? rr_q : '0;

    // Eligibility: a requesting port, restricted to the lock owner while one exists.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            eligible[p] = (|req_i[p]) && (!lock_valid_q || (lock_id_q == PW'(p)));
        end
    end

    // Winner search: first eligible port at or above rr_start, wrapping; none while clearing.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        for (int i = 0; i < NR_PORTS; i++) begin
            int sum;
            sum = int'(rr_start) + i;
            if (sum >= NR_PORTS) sum = sum - NR_PORTS;
            if (!win_valid && !clr_i && eligible[PW'(sum)]) begin
                win_valid = 1'b1;
                win_id    = PW'(sum);
            end
        end
    end

    // One-hot grant decode of the winner.
    always_comb begin
        gnt_o = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            gnt_o[p] = win_valid && (win_id == PW'(p));
        end
    end

    // SRAM command mux; the strobes are qualified so an idle cycle never touches the array.
    assign ram_req_o   = win_valid ? req_i[win_id] : '0;
    assign ram_we_o    = win_valid && we_i[win_id];
    assign ram_addr_o  = addr_i[win_id];
    assign ram_wdata_o = wdata_i[win_id];
    assign ram_be_o    = be_i[win_id];

    // Pointer, lock ownership and pending-read tracking.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            rr_q         <= '0;
            lock_valid_q <= 1'b0;
            lock_id_q    <= '0;
            id_q         <= '0;
            rd_q         <= 1'b0;
        end else begin
            if (win_valid) begin
                rr_q <= (win_id == PW'(NR_PORTS - 1)) ? '0 : win_id + PW'(1);
            end
            rd_q <= win_valid && !we_i[win_id];
            if (win_valid && !we_i[win_id]) begin
                id_q <= win_id;
            end
            // The owner keeps the lock only while it holds lock_i; a new lock
            // can only be taken by the port actually granted this cycle.
            if (lock_valid_q) begin
                if (!lock_i[lock_id_q]) lock_valid_q <= 1'b0;
            end else if (win_valid && lock_i[win_id]) begin
                lock_valid_q <= 1'b1;
                lock_id_q    <= win_id;
            end
        end
    end

    // Read return: compare every way's stored tag against the late tag of the read owner.
    always_comb begin
        hit_way_o = '0;
        rvalid_o  = '0;
        for (int w = 0; w < NR_WAYS; w++) begin
            hit_way_o[w] = rd_q && ram_valid_i[w] && (ram_tag_i[w] == tag_i[id_q]);
        end
        for (int p = 0; p < NR_PORTS; p++) begin
            rvalid_o[p] = rd_q && (id_q == PW'(p));
        end
    end

    assign hit_o       = |hit_way_o;
    // Clearing the lowest set bit leaves something only if two or more ways hit.
    assign multi_hit_o = |(hit_way_o & (hit_way_o - NR_WAYS'(1)));

endmodule
